// File: rtl/sdram_pkg.sv
// sdram_pkg: definitions shared by the SDRAM frame-buffer engines (reader, writer,
// refresh, arbiter).
//   CMD_*      4-bit SDRAM commands, encoded as {CS_N,RAS_N,CAS_N,WE_N}
//   state_t    burst engine state codes
//   A10_BIT    address bit that carries auto-precharge / precharge-all
//   clog2_min1 counter width helper that never returns 0
package sdram_pkg;

   localparam logic [3:0] CMD_NOP       = 4'b0111;
   localparam logic [3:0] CMD_ACT       = 4'b0011;
   localparam logic [3:0] CMD_WRITE     = 4'b0100;
   localparam logic [3:0] CMD_PRECHARGE = 4'b0010;

   localparam int A10_BIT = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WREQ,
      S_ACTROW,
      S_WRITE,
      S_PRECH
   } state_t;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sdram_wr_addr_gen.sv
// sdram_wr_addr_gen: beat, column, row and bank bookkeeping for the burst writer.
//   clk, rst_n  clock, synchronous active-low reset
//   beat_en     high on every WRITE-state beat
//   col         column of the burst in progress
//   next_col    column the next burst will use (already advanced on a burst's last beat)
//   row, bank   current row and ping-pong bank (bank toggles 00<->11 per frame)
//   burst_last  current beat is the final beat of the burst
//   row_end     current burst is the last one of its row
//   frame_end   current burst is the last one of the frame
module sdram_wr_addr_gen
   import sdram_pkg::*;
#(
   parameter int COL_DEPTH    = 256,
   parameter int ROW_DEPTH    = 2,
   parameter int BURST_LENGTH = 4,
   localparam int CW = clog2_min1(COL_DEPTH),
   localparam int RW = clog2_min1(ROW_DEPTH),
   localparam int BW = clog2_min1(BURST_LENGTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          beat_en,
   output logic [CW-1:0] col,
   output logic [CW-1:0] next_col,
   output logic [RW-1:0] row,
   output logic [1:0]    bank,
   output logic          burst_last,
   output logic          row_end,
   output logic          frame_end
);

   logic [BW-1:0] beat;
   logic          adv;

   assign burst_last = (beat == BW'(BURST_LENGTH - 1));
   assign row_end    = (col == CW'(COL_DEPTH - BURST_LENGTH));
   assign frame_end  = row_end && (row == RW'(ROW_DEPTH - 1));
   assign adv        = beat_en && burst_last;

   // Exposed combinationally so the top can register the next WRITE address
   // on the same edge that the column advances.
   always_comb begin
      next_col = col;
      if (adv) next_col = row_end ? '0 : col + CW'(BURST_LENGTH);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat <= '0;
         col  <= '0;
         row  <= '0;
         bank <= 2'b00;
      end else begin
         if (beat_en) beat <= burst_last ? '0 : beat + BW'(1);
         col <= next_col;
         if (adv && row_end) begin
            if (frame_end) begin
               row  <= '0;
               bank <= ~bank;
            end else begin
               row <= row + RW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/sdram_burst_writer.sv
// sdram_burst_writer: drains the write FIFO into SDRAM as ACT / WRITE-burst /
// PRECHARGE sequences, row by row, flipping the ping-pong bank every frame.
//   clk, rst_n     clock, synchronous active-low reset
//   wr_trig        start request, only looked at in IDLE
//   wr_en          arbiter grant;  wr_rq: bus request (high exactly in WREQ)
//   ref_rq         refresh pending, honoured at the next burst boundary
//   wr_end_flag    one-cycle pulse when the bus is handed back
//   wr_cmd         {CS_N,RAS_N,CAS_N,WE_N};  wr_addr / wr_bank_addr: address, bank
//   wr_dq, wr_dq_oe   write data and its output enable
//   wfifo_rd_en    FIFO pop, one cycle ahead of each beat (FIFO has 1-cycle latency)
//   wfifo_rd_data  FIFO read data
// Build option SDRAM_WR_AUTOPRE_EN: the last WRITE before PRECH carries A10=1 and
// the PRECH state issues only NOPs.
module sdram_burst_writer
   import sdram_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 12,
   parameter int ROW_DEPTH    = 2,
   parameter int COL_DEPTH    = 256,
   parameter int BURST_LENGTH = 4,
   parameter int ACT_DEPTH    = 4,
   parameter int PRE_DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_trig,
   input  logic                  wr_en,
   input  logic                  ref_rq,
   output logic                  wr_rq,
   output logic                  wr_end_flag,
   output logic [3:0]            wr_cmd,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [1:0]            wr_bank_addr,
   output logic [DATA_WIDTH-1:0] wr_dq,
   output logic                  wr_dq_oe,
   output logic                  wfifo_rd_en,
   input  logic [DATA_WIDTH-1:0] wfifo_rd_data
);

   localparam int CW    = clog2_min1(COL_DEPTH);
   localparam int RW    = clog2_min1(ROW_DEPTH);
   localparam int CNT_W = clog2_min1((ACT_DEPTH > PRE_DEPTH) ? ACT_DEPTH : PRE_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] A10_ALL = ADDR_WIDTH'(1) << A10_BIT;

   state_t                  state, next_state, prech_exit;
   logic [CNT_W-1:0]        cnt;
   logic [CW-1:0]           col, next_col;
   logic [RW-1:0]           row;
   logic [1:0]              bank;
   logic                    burst_last, row_end, frame_end;
   logic                    ref_stop, wr_a10;
   logic                    act_start, wr_start, pre_start;
   logic [ADDR_WIDTH-1:0]   wr_col_addr;

   sdram_wr_addr_gen #(
      .COL_DEPTH    (COL_DEPTH),
      .ROW_DEPTH    (ROW_DEPTH),
      .BURST_LENGTH (BURST_LENGTH)
   ) u_addr_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .beat_en    (state == S_WRITE),
      .col        (col),
      .next_col   (next_col),
      .row        (row),
      .bank       (bank),
      .burst_last (burst_last),
      .row_end    (row_end),
      .frame_end  (frame_end)
   );

   assign act_start = (next_state == S_ACTROW) && (state != S_ACTROW);
   assign wr_start  = (next_state == S_WRITE) && ((state != S_WRITE) || burst_last);
   assign pre_start = (next_state == S_PRECH) && (state != S_PRECH);

`ifdef SDRAM_WR_AUTOPRE_EN
   localparam logic [3:0]            PRE_CMD  = CMD_NOP;
   localparam logic [ADDR_WIDTH-1:0] PRE_ADDR = '0;
   logic ref_latched;
   // A10 commits the burst to auto-precharge when it is issued, so the refresh
   // decision is frozen at that moment instead of at the burst end.
   assign wr_a10   = ref_rq || (next_col == CW'(COL_DEPTH - BURST_LENGTH));
   assign ref_stop = ref_latched;
   always_ff @(posedge clk) begin
      if (!rst_n)        ref_latched <= 1'b0;
      else if (wr_start) ref_latched <= ref_rq;
   end
`else
   localparam logic [3:0]            PRE_CMD  = CMD_PRECHARGE;
   localparam logic [ADDR_WIDTH-1:0] PRE_ADDR = A10_ALL;
   assign wr_a10   = 1'b0;
   assign ref_stop = ref_rq;
`endif

   always_comb begin
      wr_col_addr              = '0;
      wr_col_addr[CW-1:0]      = next_col;
      wr_col_addr[A10_BIT]     = wr_a10;
   end

   // State register, per-state cycle counter and remembered PRECH exit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         prech_exit <= S_IDLE;
      end else begin
         state <= next_state;
         cnt   <= (next_state != state) ? '0 : cnt + CNT_W'(1);
         if (state == S_WRITE && next_state == S_PRECH)
            prech_exit <= frame_end ? S_IDLE : (ref_stop ? S_WREQ : S_ACTROW);
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (wr_trig) next_state = S_WREQ;
         S_WREQ:   if (wr_en) next_state = S_ACTROW;
         S_ACTROW: if (cnt == CNT_W'(ACT_DEPTH - 1)) next_state = S_WRITE;
         // Exits only at a burst boundary; bursts are never cut short.
         S_WRITE:  if (burst_last && (frame_end || ref_stop || row_end)) next_state = S_PRECH;
         S_PRECH:  if (cnt == CNT_W'(PRE_DEPTH - 1)) next_state = prech_exit;
         default:  next_state = S_IDLE;
      endcase
   end

   always_comb begin
      wr_rq       = (state == S_WREQ);
      wr_dq_oe    = (state == S_WRITE);
      wfifo_rd_en = rst_n && (next_state == S_WRITE);
      wr_end_flag = (state == S_PRECH) && (cnt == CNT_W'(PRE_DEPTH - 1)) &&
                    (prech_exit != S_ACTROW);
   end

   // Commands are registered from next_state so they line up with the state entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_cmd  <= CMD_NOP;
         wr_addr <= '0;
      end else begin
         wr_cmd  <= CMD_NOP;
         wr_addr <= '0;
         if (act_start) begin
            wr_cmd  <= CMD_ACT;
            wr_addr <= ADDR_WIDTH'(row);
         end else if (wr_start) begin
            wr_cmd  <= CMD_WRITE;
            wr_addr <= wr_col_addr;
         end else if (pre_start) begin
            wr_cmd  <= PRE_CMD;
            wr_addr <= PRE_ADDR;
         end
      end
   end

   assign wr_dq        = wfifo_rd_data;
   assign wr_bank_addr = bank;

endmodule

// File: tb/tb_sdram_burst_writer.sv
// tb_sdram_burst_writer: randomized sessions against a transaction-level model.
// Each session the model predicts the command stream (ACT/WRITE/PRE/end pulse with
// address, bank and cycle spacing) plus the data words; a monitor compares every
// non-NOP command, end pulse and data beat against those queues.
module tb_sdram_burst_writer;

   localparam int DW = 16, AW = 12, ROWS = 2, COLS = 256, BL = 4, ACTD = 4, PRED = 4;
   localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, WR = 4'b0100, PRE = 4'b0010;
   localparam int K_ACT = 0, K_WR = 1, K_PRE = 2, K_END = 3;

   typedef struct {
      int kind;
      int addr;
      int bank;
      bit rel_grant;
      int delta;
   } evt_t;

   logic          clk = 1'b0, rst_n = 1'b0, wr_trig = 1'b0, wr_en = 1'b0, ref_rq = 1'b0;
   logic          wr_rq, wr_end_flag, wr_dq_oe, wfifo_rd_en;
   logic [3:0]    wr_cmd;
   logic [AW-1:0] wr_addr;
   logic [1:0]    wr_bank_addr;
   logic [DW-1:0] wr_dq;
   logic [DW-1:0] wfifo_rd_data = '0;

   int   errors = 0, checks = 0;
   int   cyc = 0, grant_cyc = 0, last_cyc = 0;
   bit   in_rst = 1'b0;
   evt_t exp_q[$];
   logic [DW-1:0] fifo_q[$], dq_q[$];
   int   m_row = 0, m_col = 0, m_bank = 0;
   bit   m_idle = 1'b1;

   sdram_burst_writer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_trig       (wr_trig),
      .wr_en         (wr_en),
      .ref_rq        (ref_rq),
      .wr_rq         (wr_rq),
      .wr_end_flag   (wr_end_flag),
      .wr_cmd        (wr_cmd),
      .wr_addr       (wr_addr),
      .wr_bank_addr  (wr_bank_addr),
      .wr_dq         (wr_dq),
      .wr_dq_oe      (wr_dq_oe),
      .wfifo_rd_en   (wfifo_rd_en),
      .wfifo_rd_data (wfifo_rd_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Write FIFO with one-cycle read latency.
   always @(posedge clk)
      if (wfifo_rd_en) wfifo_rd_data <= (fifo_q.size() > 0) ? fifo_q.pop_front() : DW'('hDEAD);

   function automatic void chk(input string name, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, expv);
      end
   endfunction

   function automatic void push_evt(input int kind, input int addr, input int bank,
                                    input bit rel, input int delta);
      evt_t e;
      e.kind = kind; e.addr = addr; e.bank = bank; e.rel_grant = rel; e.delta = delta;
      exp_q.push_back(e);
   endfunction

   // Predicts one granted session: bursts until frame end or the k-th burst
   // (refresh yield), with a precharge/re-activate at each row boundary.
   task automatic model_push(input int k);
      bit last, frame, after_act;
      logic [DW-1:0] w;
      push_evt(K_ACT, m_row, m_bank, 1'b1, 1);
      after_act = 1'b1;
      for (int b = 0; b < 100000; b++) begin
         push_evt(K_WR, m_col, m_bank, 1'b0, after_act ? ACTD : BL);
         after_act = 1'b0;
         for (int j = 0; j < BL; j++) begin
            w = DW'($urandom());
            fifo_q.push_back(w);
            dq_q.push_back(w);
         end
         last  = (m_col == COLS - BL);
         frame = last && (m_row == ROWS - 1);
         if (last) begin
            m_col = 0;
            if (frame) begin
               m_row  = 0;
               m_bank = 3 - m_bank;
            end else begin
               m_row = m_row + 1;
            end
         end else begin
            m_col = m_col + BL;
         end
         if (frame || (b + 1 == k)) begin
            push_evt(K_PRE, 'h400, 0, 1'b0, BL);
            push_evt(K_END, 0, 0, 1'b0, PRED - 1);
            m_idle = frame;
            return;
         end
         if (last) begin
            push_evt(K_PRE, 'h400, 0, 1'b0, BL);
            push_evt(K_ACT, m_row, m_bank, 1'b0, PRED);
            after_act = 1'b1;
         end
      end
   endtask

   // Monitor: compares everything the DUT presents against the queues.
   always @(negedge clk) begin
      evt_t e;
      int   kind;
      if (rst_n && !in_rst) begin
         if (wr_rq && wr_en) grant_cyc = cyc;
         if (wr_rq)
            chk("rq_only_while_waiting",
                int'(exp_q.size() == 0 || (exp_q[0].kind == K_ACT && exp_q[0].rel_grant)), 1);
         if (wr_cmd != NOP) begin
            kind = (wr_cmd == ACT) ? K_ACT : (wr_cmd == WR) ? K_WR : (wr_cmd == PRE) ? K_PRE : -1;
            if (exp_q.size() == 0) begin
               chk("cmd_unexpected", int'(wr_cmd), int'(NOP));
            end else begin
               e = exp_q.pop_front();
               chk("cmd_kind", kind, e.kind);
               chk("cmd_addr", int'(wr_addr), e.addr);
               if (e.kind != K_PRE) chk("cmd_bank", int'(wr_bank_addr), e.bank);
               chk("cmd_spacing", cyc - (e.rel_grant ? grant_cyc : last_cyc), e.delta);
            end
            last_cyc = cyc;
         end
         if (wr_end_flag) begin
            if (exp_q.size() == 0) begin
               chk("end_unexpected", int'(wr_end_flag), 0);
            end else begin
               e = exp_q.pop_front();
               chk("end_kind", e.kind, K_END);
               chk("end_spacing", cyc - last_cyc, e.delta);
            end
         end
         if (wr_dq_oe) begin
            if (dq_q.size() == 0) chk("dq_unexpected", int'(wr_dq_oe), 0);
            else                  chk("dq_data", int'(wr_dq), int'(dq_q.pop_front()));
         end
      end
   end

   task automatic apply_mid_burst_reset();
      wr_trig = 1'b0;
      @(posedge clk); #1;            // beat 1
      @(posedge clk); #1;            // beat 2
      in_rst = 1'b1;
      rst_n  = 1'b0;
      ref_rq = 1'b0;
      @(posedge clk); #1;
      chk("midrst_cmd_nop", int'(wr_cmd), int'(NOP));
      chk("midrst_oe", int'(wr_dq_oe), 0);
      chk("midrst_bank", int'(wr_bank_addr), 0);
      chk("midrst_addr", int'(wr_addr), 0);
      exp_q.delete();
      fifo_q.delete();
      dq_q.delete();
      m_row = 0; m_col = 0; m_bank = 0; m_idle = 1'b1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      in_rst = 1'b0;
      chk("midrst_rq", int'(wr_rq), 0);
      chk("midrst_rd_en", int'(wfifo_rd_en), 0);
   endtask

   // One bus tenure: trigger if idle, grant, then yield via refresh after k bursts,
   // run to frame end, or (rst_at > 0) reset during beat 2 of burst rst_at.
   task automatic do_session(input int k, input int rst_at);
      int n, t;
      bit done;
      if (m_idle) begin
         wr_trig = 1'b1;
         @(posedge clk); #1;
         wr_trig = 1'b0;
      end
      t = 0;
      while (!wr_rq && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      chk("rq_after_trigger", int'(wr_rq), 1);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      model_push(k);
      wr_en = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0;
      n = 0; done = 1'b0; t = 0;
      while (!done && t < 3000) begin
         if (wr_cmd == WR) begin
            n++;
            if (n == k && rst_at == 0) ref_rq = 1'b1;
            if (n == rst_at) begin
               apply_mid_burst_reset();
               done = 1'b1;
            end
         end
         if (!done && wr_end_flag) done = 1'b1;
         if (!done) begin
            wr_trig = 1'($urandom_range(0, 1));   // must be ignored outside IDLE
            @(posedge clk); #1;
            t++;
         end
      end
      wr_trig = 1'b0;
      ref_rq  = 1'b0;
      chk("session_done", int'(done), 1);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd", int'(wr_cmd), int'(NOP));
      chk("rst_addr", int'(wr_addr), 0);
      chk("rst_bank", int'(wr_bank_addr), 0);
      chk("rst_oe", int'(wr_dq_oe), 0);
      chk("rst_rq", int'(wr_rq), 0);
      chk("rst_end", int'(wr_end_flag), 0);
      chk("rst_rd_en", int'(wfifo_rd_en), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_session(3, 0);                          // cols 0,4,8 then refresh yield
      do_session(2, 0);                          // resumes at col 12
      for (int i = 0; i < 12; i++) do_session($urandom_range(1, 25), 0);
      do_session(1000, 0);                       // run to frame end
      do_session(1000, 0);                       // full frame in the other bank
      do_session(1000, $urandom_range(1, 10));   // reset mid-burst
      do_session(5, 0);                          // restart from row 0 col 0 bank 00
      do_session(1000, 0);

      repeat (5) @(posedge clk);
      #1;
      chk("cmd_queue_drained", exp_q.size(), 0);
      chk("data_queue_drained", dq_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
